// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: y[j] = sat((b[j]<<FRAC + sum_i x[i]*w[j*IN+i]) >>> FRAC).
// Optional build macro FC_RELU_EN clamps negative results to zero on out_value.
module fc_layer_engine #(
  parameter int IN_CELL  = 14,
  parameter int OUT_CELL = 10,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_we,
  input  logic [1:0]        ex_sel,
  input  logic [15:0]       ex_addr,
  input  logic [DATA_W-1:0] ex_value,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  output logic [15:0]       out_idx,
  output logic [DATA_W-1:0] out_value,
  output logic              done,
  output logic              ovf
);

  localparam int ACC_W   = 2*DATA_W + $clog2(IN_CELL) + 1;
  localparam int W_DEPTH = IN_CELL*OUT_CELL;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] x_q [IN_CELL];
  logic signed [DATA_W-1:0] x_d [IN_CELL];
  logic signed [DATA_W-1:0] w_q [W_DEPTH];
  logic signed [DATA_W-1:0] w_d [W_DEPTH];
  logic signed [DATA_W-1:0] b_q [OUT_CELL];
  logic signed [DATA_W-1:0] b_d [OUT_CELL];

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]             i_q, i_d, j_q, j_d, wp_q, wp_d;
  logic                    busy_q, busy_d, out_valid_q, out_valid_d;
  logic                    done_q, done_d, ovf_q, ovf_d;
  logic [15:0]             out_idx_q, out_idx_d;
  logic [DATA_W-1:0]       out_value_q, out_value_d;

  logic                      wr_ok, start_ok;
  logic [15:0]               bsel_idx;
  logic signed [DATA_W-1:0]  x_sel, w_sel, b_sel;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext, bias_init, r;
  logic                      clamp;
  logic [DATA_W-1:0]         sat_val, res;

  assign wr_ok    = ex_we && (state_q == S_IDLE);
  assign start_ok = start && (state_q == S_IDLE);

  // RAM write decode; reads of bias use b_d so a write coinciding with start is seen
  always_comb begin
    x_d = x_q;
    w_d = w_q;
    b_d = b_q;
    if (wr_ok) begin
      case (ex_sel)
        2'd0: for (int unsigned k = 0; k < IN_CELL; k++)
                if (ex_addr == 16'(k)) x_d[k] = ex_value;
        2'd1: for (int unsigned k = 0; k < W_DEPTH; k++)
                if (ex_addr == 16'(k)) w_d[k] = ex_value;
        2'd2: for (int unsigned k = 0; k < OUT_CELL; k++)
                if (ex_addr == 16'(k)) b_d[k] = ex_value;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    x_q <= x_d;
    w_q <= w_d;
    b_q <= b_d;
  end

  always_comb begin
    x_sel = '0;
    w_sel = '0;
    b_sel = '0;
    bsel_idx = (state_q == S_IDLE) ? 16'd0 : j_q + 16'd1;
    for (int unsigned k = 0; k < IN_CELL; k++)
      if (i_q == 16'(k)) x_sel = x_q[k];
    for (int unsigned k = 0; k < W_DEPTH; k++)
      if (wp_q == 16'(k)) w_sel = w_q[k];
    for (int unsigned k = 0; k < OUT_CELL; k++)
      if (bsel_idx == 16'(k)) b_sel = b_d[k];
    prod      = x_sel * w_sel;
    prod_ext  = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    bias_init = {{(ACC_W-DATA_W){b_sel[DATA_W-1]}}, b_sel};
    bias_init = bias_init <<< FRAC_W;
  end

  always_comb begin
    r       = acc_q >>> FRAC_W;
    clamp   = 1'b0;
    sat_val = r[DATA_W-1:0];
    if (r > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
      clamp   = 1'b1;
    end else if (r < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
      clamp   = 1'b1;
    end
`ifdef FC_RELU_EN
    res = sat_val[DATA_W-1] ? '0 : sat_val;
`else
    res = sat_val;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_MAC;
      S_MAC:   if (i_q == 16'(IN_CELL-1)) state_d = S_OUT;
      S_OUT:   state_d = (j_q == 16'(OUT_CELL-1)) ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    wp_d        = wp_q;
    busy_d      = done_q ? 1'b0 : busy_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    out_idx_d   = out_idx_q;
    out_value_d = out_value_q;
    case (state_q)
      S_IDLE: if (start_ok) begin
        acc_d  = bias_init;
        i_d    = '0;
        j_d    = '0;
        wp_d   = '0;
        ovf_d  = 1'b0;
        busy_d = 1'b1;
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        i_d   = i_q + 16'd1;
        wp_d  = wp_q + 16'd1;
      end
      S_OUT: begin
        out_valid_d = 1'b1;
        out_idx_d   = j_q;
        out_value_d = res;
        if (clamp) ovf_d = 1'b1;
        if (j_q != 16'(OUT_CELL-1)) begin
          j_d   = j_q + 16'd1;
          i_d   = '0;
          acc_d = bias_init;
        end
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      wp_q        <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_idx_q   <= '0;
      out_value_q <= '0;
    end else begin
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      wp_q        <= wp_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      out_idx_q   <= out_idx_d;
      out_value_q <= out_value_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_value = out_value_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine with IN_CELL=4, OUT_CELL=2, Q5.10 data.
module tb_fc_layer_engine;

  localparam int IN_CELL  = 4;
  localparam int OUT_CELL = 2;
  localparam int DATA_W   = 16;
  localparam int FRAC_W   = 10;
`ifdef FC_RELU_EN
  localparam int Y1 = 0;
`else
  localparam int Y1 = -3840;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_we;
  logic [1:0]        ex_sel;
  logic [15:0]       ex_addr;
  logic [DATA_W-1:0] ex_value;
  logic              start;
  logic              busy, out_valid, done, ovf;
  logic [15:0]       out_idx;
  logic [DATA_W-1:0] out_value;

  fc_layer_engine #(.IN_CELL(IN_CELL), .OUT_CELL(OUT_CELL), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .reset(reset), .ex_we(ex_we), .ex_sel(ex_sel), .ex_addr(ex_addr),
    .ex_value(ex_value), .start(start), .busy(busy), .out_valid(out_valid),
    .out_idx(out_idx), .out_value(out_value), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit kind;
    int idx;
    int value;
    int ofs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every out_valid/done strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && (out_valid || done)) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: valid=%0d done=%0d idx=%0d value=%0d, required none",
                 out_valid, done, out_idx, $signed(out_value));
      end else begin
        e = exp_q.pop_front();
        if (e.kind == 1'b0) begin
          if (!out_valid || out_idx != 16'(e.idx) || $signed(out_value) != e.value ||
              cyc - start_cyc != e.ofs) begin
            failures++;
            $display("FAIL out_%0d: valid=%0d idx=%0d value=%0d cycle=%0d, required idx=%0d value=%0d cycle=%0d",
                     e.idx, out_valid, out_idx, $signed(out_value), cyc - start_cyc,
                     e.idx, e.value, e.ofs);
          end
        end else if (!done || out_valid || cyc - start_cyc != e.ofs) begin
          failures++;
          $display("FAIL done_pulse: done=%0d valid=%0d cycle=%0d, required done=1 cycle=%0d",
                   done, out_valid, cyc - start_cyc, e.ofs);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input int addr, input int val);
    ex_we    = 1'b1;
    ex_sel   = sel;
    ex_addr  = 16'(addr);
    ex_value = DATA_W'(val);
    tick();
    ex_we    = 1'b0;
  endtask

  task automatic push_out(input int idx, input int val, input int ofs);
    exp_t e;
    e.kind = 1'b0; e.idx = idx; e.value = val; e.ofs = ofs;
    exp_q.push_back(e);
  endtask

  task automatic push_run(input int v0, input int v1);
    exp_t e;
    push_out(0, v0, IN_CELL + 1);
    push_out(1, v1, 2*(IN_CELL + 1));
    e.kind = 1'b1; e.idx = 0; e.value = 0; e.ofs = 2*(IN_CELL + 1) + 1;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({name, "_done_timeout"}, 0, 1);
    tick();
    tick();
    chk({name, "_busy_idle"}, int'(busy), 0);
    chk({name, "_sb_drained"}, exp_q.size(), 0);
  endtask

  task automatic load_base();
    for (int i = 0; i < IN_CELL; i++) begin
      wr(2'd0, i, 1024);
      wr(2'd1, i, 512);
      wr(2'd1, IN_CELL + i, -1024);
    end
    wr(2'd2, 0, 0);
    wr(2'd2, 1, 256);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_out_valid"}, int'(out_valid), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_ovf"}, int'(ovf), 0);
    chk({name, "_out_idx"}, int'(out_idx), 0);
    chk({name, "_out_value"}, int'(out_value), 0);
  endtask

  initial begin
    reset = 1'b1; ex_we = 1'b0; ex_sel = '0; ex_addr = '0; ex_value = '0; start = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Basic computation with exact timing
    load_base();
    push_run(2048, Y1);
    do_start();
    wait_done("basic");
    chk("basic_ovf", int'(ovf), 0);

    // Positive saturation, then ovf cleared by a non-saturating run
    for (int i = 0; i < IN_CELL; i++) wr(2'd0, i, 32767);
    for (int i = 0; i < IN_CELL*OUT_CELL; i++) wr(2'd1, i, 32767);
    push_run(32767, 32767);
    do_start();
    wait_done("sat");
    chk("sat_ovf", int'(ovf), 1);
    load_base();
    push_run(2048, Y1);
    do_start();
    chk("ovf_cleared_on_start", int'(ovf), 0);
    wait_done("unsat");
    chk("unsat_ovf", int'(ovf), 0);

    // Start and write while busy are ignored
    push_run(2048, Y1);
    do_start();
    tick();
    tick();
    start = 1'b1; ex_we = 1'b1; ex_sel = 2'd0; ex_addr = 16'd0; ex_value = 16'd5;
    tick();
    start = 1'b0; ex_we = 1'b0;
    wait_done("busy_ignore");

    // Reset mid-computation, RAMs retained
    push_out(0, 2048, IN_CELL + 1);
    do_start();
    repeat (6) tick();
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    tick();
    reset = 1'b0;
    tick();
    chk("midreset_sb_drained", exp_q.size(), 0);
    push_run(2048, Y1);
    do_start();
    wait_done("after_reset");

    // Out-of-range and reserved-target writes are dropped
    wr(2'd0, IN_CELL, 7777);
    wr(2'd3, 0, 7777);
    wr(2'd3, 1, 7777);
    push_run(2048, Y1);
    do_start();
    wait_done("dropped_wr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
